shooter_renderer: RTL and testbench

- Pixel-generation stage directly downstream of the VGA timing generator.
- Consumes pixel position, blanking and sync signals; runs a once-per-frame game update:
  - player ship moves left/right;
  - single bullet state machine.
- Produces registered 1-bit RGB plus syncs delayed to stay aligned with the pixels.
- Sits between the timing generator and the board VGA pins.

---
 rtl/shooter_renderer.sv | 182 ++++++++++++++++++
 tb/tb_shooter_renderer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shooter_renderer.sv
// Pixel stage behind the VGA timing generator: ship, one bullet,
// registered 1-bit RGB and syncs delayed one clock to match.
module shooter_renderer #(
  parameter int H_ACTIVE    = 299,
  parameter int V_ACTIVE    = 476,
  parameter int SHIP_W      = 16,
  parameter int SHIP_H      = 8,
  parameter int SHIP_Y      = 460,
  parameter int SHIP_STEP   = 2,
  parameter int BULLET_W    = 2,
  parameter int BULLET_H    = 6,
  parameter int BULLET_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] V_pos,
  input  logic [8:0] H_pos,
  input  logic       VGA_enable,
  input  logic       V_sync,
  input  logic       H_sync,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic       V_sync_o,
  output logic       H_sync_o
);

  localparam logic [9:0] L_SHIP_MAX = 10'(H_ACTIVE - SHIP_W);
  localparam logic [8:0] L_SHIP_RST = 9'((H_ACTIVE - SHIP_W) / 2);
  localparam logic [9:0] L_SHIP_W   = 10'(SHIP_W);
  localparam logic [9:0] L_SHIP_H   = 10'(SHIP_H);
  localparam logic [9:0] L_SHIP_Y   = 10'(SHIP_Y);
  localparam logic [9:0] L_STEP     = 10'(SHIP_STEP);
  localparam logic [9:0] L_BW       = 10'(BULLET_W);
  localparam logic [9:0] L_BH       = 10'(BULLET_H);
  localparam logic [9:0] L_BSTEP    = 10'(BULLET_STEP);
  localparam logic [8:0] L_B_Y0     = 9'(SHIP_Y - BULLET_H);
  localparam logic [8:0] L_B_XOFF   = 9'd7;
  localparam int         L_UNUSED   = V_ACTIVE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLY,
    S_WAIT
  } bstate_t;

  logic [2:0] r_btn_s1;
  logic [2:0] r_btn_s2;
  logic       r_v_prev;
  logic [8:0] r_ship_x;
  bstate_t    r_state;
  logic [8:0] r_bx;
  logic [8:0] r_by;

  logic       w_tick;
  logic       w_left;
  logic       w_right;
  logic       w_fire;
  logic [9:0] w_inc;
  logic [9:0] w_dec;
  logic [8:0] w_ship_nxt;
  bstate_t    w_state_nxt;
  logic [8:0] w_bx_nxt;
  logic [8:0] w_by_nxt;
  logic [9:0] w_h;
  logic [9:0] w_v;
  logic [9:0] w_sx;
  logic [9:0] w_bx;
  logic [9:0] w_by;
  logic       w_ship_hit;
  logic       w_bullet_hit;

  assign w_tick  = r_v_prev & ~V_sync;
  assign w_left  = r_btn_s2[0];
  assign w_right = r_btn_s2[1];
  assign w_fire  = r_btn_s2[2];

  // Two-flop button synchronizers and previous V_sync for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_v_prev <= 1'b0;
    end else begin
      r_btn_s1 <= {btn_fire, btn_right, btn_left};
      r_btn_s2 <= r_btn_s1;
      r_v_prev <= V_sync;
    end
  end

  // Ship position with saturating move, no wrap below zero
  always_comb begin
    w_inc      = {1'b0, r_ship_x} + L_STEP;
    w_dec      = {1'b0, r_ship_x} - L_STEP;
    w_ship_nxt = r_ship_x;
    if (w_left && !w_right) begin
      if ({1'b0, r_ship_x} < L_STEP) w_ship_nxt = '0;
      else w_ship_nxt = w_dec[8:0];
    end else if (w_right && !w_left) begin
      if (w_inc > L_SHIP_MAX) w_ship_nxt = L_SHIP_MAX[8:0];
      else w_ship_nxt = w_inc[8:0];
    end
  end

  // Ship register, updated once per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ship_x <= L_SHIP_RST;
    else if (w_tick) r_ship_x <= w_ship_nxt;
  end

  // Bullet next state: launch, climb, then wait for fire release
  always_comb begin
    w_state_nxt = r_state;
    w_bx_nxt    = r_bx;
    w_by_nxt    = r_by;
    unique case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          w_state_nxt = S_FLY;
          w_bx_nxt    = r_ship_x + L_B_XOFF;
          w_by_nxt    = L_B_Y0;
        end
      end
      S_FLY: begin
        if ({1'b0, r_by} < L_BSTEP)
          w_state_nxt = w_fire ? S_WAIT : S_IDLE;
        else
          w_by_nxt = r_by - L_BSTEP[8:0];
      end
      S_WAIT: begin
        if (!w_fire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bullet state register, advances only on the frame tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bx    <= '0;
      r_by    <= '0;
    end else if (w_tick) begin
      r_state <= w_state_nxt;
      r_bx    <= w_bx_nxt;
      r_by    <= w_by_nxt;
    end
  end

  assign w_h  = {1'b0, H_pos};
  assign w_v  = {1'b0, V_pos};
  assign w_sx = {1'b0, r_ship_x};
  assign w_bx = {1'b0, r_bx};
  assign w_by = {1'b0, r_by};

  assign w_ship_hit = (w_h >= w_sx) && (w_h < w_sx + L_SHIP_W)
                   && (w_v >= L_SHIP_Y) && (w_v < L_SHIP_Y + L_SHIP_H);

  assign w_bullet_hit = (r_state == S_FLY)
                     && (w_h >= w_bx) && (w_h < w_bx + L_BW)
                     && (w_v >= w_by) && (w_v < w_by + L_BH);

  // Registered colour with bullet over ship over background
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {red, green, blue} <= 3'b000;
      V_sync_o           <= 1'b0;
      H_sync_o           <= 1'b0;
    end else begin
      V_sync_o <= V_sync;
      H_sync_o <= H_sync;
      if (!VGA_enable)       {red, green, blue} <= 3'b000;
      else if (w_bullet_hit) {red, green, blue} <= 3'b100;
      else if (w_ship_hit)   {red, green, blue} <= 3'b010;
      else                   {red, green, blue} <= 3'b001;
    end
  end

endmodule

// File: tb/tb_shooter_renderer.sv
// Directed bench for shooter_renderer: frame-level game model
// plus per-cycle output compare and literal pixel expectations.
module tb_shooter_renderer;

  logic       clk;
  logic       rst_n;
  logic [8:0] V_pos;
  logic [8:0] H_pos;
  logic       VGA_enable;
  logic       V_sync;
  logic       H_sync;
  logic       btn_left;
  logic       btn_right;
  logic       btn_fire;
  logic       red;
  logic       green;
  logic       blue;
  logic       V_sync_o;
  logic       H_sync_o;

  shooter_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .V_pos      (V_pos),
    .H_pos      (H_pos),
    .VGA_enable (VGA_enable),
    .V_sync     (V_sync),
    .H_sync     (H_sync),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_fire   (btn_fire),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .V_sync_o   (V_sync_o),
    .H_sync_o   (H_sync_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // game model: ship x, bullet state (0 idle, 1 flying, 2 waiting)
  int       m_sx;
  int       m_st;
  int       m_bx;
  int       m_by;
  int       m_launch;
  bit       m_vp;
  bit [2:0] m_d1;
  bit [2:0] m_d2;

  logic [2:0] exp_rgb;
  logic       exp_vs;
  logic       exp_hs;
  bit         lit_on;
  logic [2:0] lit_rgb;
  string      lit_name;

  task automatic model_reset();
    m_sx = 141; m_st = 0; m_bx = 0; m_by = 0;
    m_vp = 0; m_d1 = 0; m_d2 = 0;
    exp_rgb = 0; exp_vs = 0; exp_hs = 0;
  endtask

  task automatic tick(input bit [2:0] b);
    int old;
    old = m_sx;
    if (b[0] && !b[1]) m_sx = (m_sx < 2) ? 0 : m_sx - 2;
    if (b[1] && !b[0]) m_sx = (m_sx + 2 > 283) ? 283 : m_sx + 2;
    case (m_st)
      0: if (b[2]) begin
           m_st = 1; m_bx = old + 7; m_by = 454; m_launch++;
         end
      1: if (m_by < 4) m_st = b[2] ? 2 : 0;
         else m_by = m_by - 4;
      default: if (!b[2]) m_st = 0;
    endcase
  endtask

  // expected outputs after the next edge, then advance the model
  task automatic apply();
    int h, v;
    h = int'(H_pos);
    v = int'(V_pos);
    if (!VGA_enable) exp_rgb = 3'b000;
    else if (m_st == 1 && h >= m_bx && h < m_bx + 2
             && v >= m_by && v < m_by + 6) exp_rgb = 3'b100;
    else if (h >= m_sx && h < m_sx + 16
             && v >= 460 && v < 468) exp_rgb = 3'b010;
    else exp_rgb = 3'b001;
    exp_vs = V_sync;
    exp_hs = H_sync;
    if (m_vp && !V_sync) tick(m_d2);
    m_vp = V_sync;
    m_d2 = m_d1;
    m_d1 = {btn_fire, btn_right, btn_left};
  endtask

  task automatic check_out();
    n_vec++;
    if ({red, green, blue, V_sync_o, H_sync_o}
        !== {exp_rgb, exp_vs, exp_hs}) begin
      n_err++;
      $display("FAIL cycle @%0t: rgb/vs/hs got %b%b%b %b %b want %b %b %b",
               $time, red, green, blue, V_sync_o, H_sync_o,
               exp_rgb, exp_vs, exp_hs);
    end
    if (lit_on) begin
      n_vec++;
      lit_on = 0;
      if ({red, green, blue} !== lit_rgb) begin
        n_err++;
        $display("FAIL %s: rgb got %b%b%b want %b",
                 lit_name, red, green, blue, lit_rgb);
      end
    end
  endtask

  task automatic step(input logic vs, input logic en,
                      input logic [8:0] h, input logic [8:0] v,
                      input logic [2:0] btn);
    @(negedge clk);
    check_out();
    V_sync = vs;
    H_sync = 1'($urandom_range(0, 1));
    VGA_enable = en;
    H_pos = h;
    V_pos = v;
    {btn_fire, btn_right, btn_left} = btn;
    apply();
  endtask

  task automatic pix(input int h, input int v, input logic en,
                     input logic [2:0] lit, input string nm);
    step(1'b0, en, 9'(h), 9'(v), 3'b000);
    lit_on = 1;
    lit_rgb = lit;
    lit_name = nm;
  endtask

  task automatic frame(input logic [2:0] btn);
    for (int i = 0; i < 5; i++)
      step(i < 3, 1'($urandom_range(0, 3) != 0),
           9'($urandom_range(0, 298)),
           9'($urandom_range(440, 475)), btn);
  endtask

  task automatic frames(input int n, input logic [2:0] btn);
    for (int i = 0; i < n; i++) frame(btn);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    check_out();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({red, green, blue, V_sync_o, H_sync_o} !== 5'b0) begin
      n_err++;
      $display("FAIL async_reset: outputs got %b%b%b %b %b want 0 0",
               red, green, blue, V_sync_o, H_sync_o);
    end
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_out();
    end
    @(negedge clk);
    check_out();
    rst_n = 1'b1;
    apply();
  endtask

  int l0;

  initial begin
    rst_n = 1'b0;
    V_pos = 0; H_pos = 0; VGA_enable = 0;
    V_sync = 0; H_sync = 0;
    btn_left = 0; btn_right = 0; btn_fire = 0;
    lit_on = 0;
    m_launch = 0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_out();
    end
    rst_n = 1'b1;
    apply();

    // reset frame: ship box, edges, blanking
    frames(1, 3'b000);
    pix(141, 460, 1, 3'b010, "ship_tl");
    pix(156, 467, 1, 3'b010, "ship_br");
    pix(140, 460, 1, 3'b001, "left_of_ship");
    pix(157, 460, 1, 3'b001, "right_of_ship");
    pix(141, 459, 1, 3'b001, "above_ship");
    pix(141, 460, 0, 3'b000, "blank");
    chk("ship_reset", m_sx, 141);

    // launch from x=141
    frames(1, 3'b100);
    chk("launch_state", m_st, 1);
    chk("launch_bx", m_bx, 148);
    chk("launch_by", m_by, 454);
    pix(148, 454, 1, 3'b100, "bullet_tl");
    pix(149, 459, 1, 3'b100, "bullet_br");
    pix(150, 454, 1, 3'b001, "bullet_right");
    pix(148, 453, 1, 3'b001, "bullet_above");
    frames(1, 3'b000);
    chk("bullet_tick1", m_by, 450);
    pix(148, 450, 1, 3'b100, "bullet_y450");
    frames(112, 3'b000);
    chk("bullet_tick113", m_by, 2);
    pix(149, 7, 1, 3'b100, "bullet_y2");
    frames(1, 3'b000);
    chk("bullet_end", m_st, 0);
    pix(148, 2, 1, 3'b001, "no_bullet");

    // held fire gives one shot then parks
    l0 = m_launch;
    frames(300, 3'b100);
    chk("one_shot", m_launch - l0, 1);
    chk("parked", m_st, 2);
    pix(148, 2, 1, 3'b001, "parked_dark");
    frames(1, 3'b000);
    chk("released", m_st, 0);
    frames(1, 3'b100);
    chk("relaunch", m_launch - l0, 2);
    pix(148, 454, 1, 3'b100, "relaunch_px");
    frames(120, 3'b000);

    // ship movement and clamps
    frames(100, 3'b010);
    chk("ship_right_sat", m_sx, 283);
    pix(283, 460, 1, 3'b010, "ship_at_283");
    pix(298, 467, 1, 3'b010, "ship_edge_298");
    pix(282, 460, 1, 3'b001, "left_of_283");
    frames(200, 3'b001);
    chk("ship_left_sat", m_sx, 0);
    pix(0, 460, 1, 3'b010, "ship_at_0");
    pix(16, 460, 1, 3'b001, "right_of_0");
    frames(10, 3'b010);
    chk("ship_right10", m_sx, 20);
    frames(5, 3'b011);
    chk("ship_both", m_sx, 20);
    pix(20, 463, 1, 3'b010, "ship_at_20");

    // reset during flight
    frames(1, 3'b100);
    chk("mid_bx", m_bx, 27);
    frames(1, 3'b000);
    pix(27, 450, 1, 3'b100, "pre_reset_bullet");
    reset_mid();
    frames(1, 3'b000);
    chk("post_reset_state", m_st, 0);
    pix(141, 460, 1, 3'b010, "post_reset_ship");
    pix(27, 450, 1, 3'b001, "post_reset_nobullet");
    step(1'b0, 1'b0, 9'd0, 9'd0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
